sqrt_sched: RTL
===============

SQRT_SCHED -- requirements
Module: sqrt_sched

Interface
REQ-001 Parameters SHALL be NREQ default 4 (requester count, >=2); WIDTH default 8 (radicand/root width); TIMEOUT default 64 (max engine cycles per operation, used only with the watchdog).
REQ-002 Ports SHALL be:
- clk  in  1  -- sole clock; all logic on the rising edge.
- rst_n  in  1  -- reset, synchronous, active-low.
- req_valid  in  NREQ  -- per-requester request.
- req_rad  in  NREQ x WIDTH  -- per-requester radicand.
- req_ready  out  NREQ  -- one-hot acceptance pulse.
- rsp_valid  out  1  -- result available.
- rsp_ready  in  1  -- result consumed.
- rsp_id  out  clog2(NREQ)  -- requester index of the result.
- rsp_root  out  WIDTH  -- root.
- rsp_rem  out  WIDTH  -- remainder.
- rsp_err  out  1  -- watchdog expiry flag.
- eng_start  out  1  -- one-cycle start to the iterative sqrt engine.
- eng_rad  out  WIDTH  -- engine radicand.
- eng_busy  in  1  -- engine busy.
- eng_valid  in  1  -- engine result valid.
- eng_root  in  WIDTH  -- engine root.
- eng_rem  in  WIDTH  -- engine remainder.

Function
REQ-003 The FSM SHALL have states IDLE, START, WAIT and HOLD.
REQ-004 IDLE SHALL move to START when any req_valid bit is 1 and eng_busy is 0.
REQ-005 On the IDLE->START transition:
- Assert req_ready for the round-robin winner only, for exactly that cycle.
- Register the winner's req_rad and its index.
REQ-006 Round-robin SHALL search from pointer upward, wrapping from NREQ-1 to 0; after a grant, pointer SHALL become winner+1 modulo NREQ.
REQ-007 START SHALL hold eng_start=1 and eng_rad=captured radicand for exactly one cycle, then go to WAIT; eng_start SHALL be 0 in all other states.
REQ-008 WAIT SHALL go to HOLD on the first cycle with eng_valid=1 and eng_busy=0, registering eng_root, eng_rem and rsp_err=0.
REQ-009 HOLD SHALL assert rsp_valid, with rsp_id/rsp_root/rsp_rem/rsp_err stable, until a cycle with rsp_ready=1, then go to IDLE.
REQ-010 The result SHALL appear on rsp_* one cycle after eng_valid rises; minimum acceptance-to-rsp_valid latency is 2 cycles plus the engine latency.
REQ-011 At most one operation SHALL be outstanding; req_ready SHALL be 0 in START, WAIT and HOLD.
REQ-012 A requester that drops req_valid before being granted SHALL simply not be granted; req_rad of non-winners SHALL be ignored.
REQ-013 rsp_ready asserted outside HOLD SHALL have no effect.
REQ-014 After HOLD->IDLE, the earliest next grant SHALL occur in the following cycle, i.e. one idle cycle between operations.

Reset
REQ-015 While rst_n=0 at a clock edge:
- FSM goes to IDLE and pointer to 0.
- req_ready, eng_start, rsp_valid and rsp_err go to 0.
- rsp_id, rsp_root, rsp_rem and eng_rad go to 0.
REQ-016 A reset in START, WAIT or HOLD SHALL abandon the operation with no response.
REQ-017 After a reset, the next grant SHALL wait until eng_busy=0, which covers an engine still running an abandoned operation.

Configuration
REQ-018 With macro SQRT_SCHED_TIMEOUT_EN defined:
- A counter SHALL clear on entry to WAIT and increment each WAIT cycle.
- When it reaches TIMEOUT without eng_valid, the FSM SHALL go to HOLD with rsp_err=1 and rsp_root=rsp_rem=0.
REQ-019 Without SQRT_SCHED_TIMEOUT_EN:
- No counter SHALL exist.
- rsp_err SHALL be tied to 0.
- WAIT SHALL wait indefinitely.

Structure
REQ-020 Package sqrt_sched_pkg SHALL hold:
- the FSM state enum type;
- the default NREQ/WIDTH/TIMEOUT constants;
- the id-width constant function.
REQ-021 Round-robin selection SHALL be a separate sub-module rr_arbiter with inputs req, pointer and enable, and outputs one-hot grant and encoded index.

Verification
REQ-022 Bench (NREQ=4, WIDTH=8, engine model latency 4 cycles) SHALL cover:
- Single request on requester 2 with rad=81 -> one req_ready[2] pulse; rsp_id=2, rsp_root=9, rsp_rem=0.
- rad=80 on requester 0 -> rsp_root=8, rsp_rem=16.
- All four req_valid held high for 8 operations -> grant order 0,1,2,3,0,1,2,3; never two req_ready bits high together.
- rsp_ready held low 5 cycles in HOLD -> rsp_valid and fields stable throughout; IDLE entered the cycle after rsp_ready=1.
- rst_n pulsed low during WAIT with eng_busy=1 -> all outputs 0; no grant until eng_busy=0; pointer restarts at 0.
- With SQRT_SCHED_TIMEOUT_EN and an engine that never asserts eng_valid -> rsp_valid with rsp_err=1 after TIMEOUT WAIT cycles; the next request is still served.

Source files
------------

// File: rtl/sqrt_sched_pkg.sv
// ============================================================================
// sqrt_sched_pkg : shared types and defaults for the sqrt request scheduler
// Revision: 1.0
// ============================================================================
`default_nettype none

package sqrt_sched_pkg;

  localparam int c_nreq_def    = 4;
  localparam int c_width_def   = 8;
  localparam int c_timeout_def = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_e;

  // Index width, never narrower than one bit
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sqrt_sched_rr_arbiter.sv
// ============================================================================
// rr_arbiter : round-robin selector, searching upward from pointer with wrap
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  pointer,
  input  logic            enable,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  index
);

  int             w_k;
  logic [IDW-1:0] w_sel;
  logic           w_found;

  always_comb begin
    grant   = '0;
    index   = '0;
    w_found = 1'b0;
    w_k     = 0;
    w_sel   = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_k = int'(pointer) + i;
      if (w_k >= NREQ) w_k = w_k - NREQ;
      w_sel = IDW'(w_k);
      if (enable && !w_found && req[w_sel]) begin
        w_found      = 1'b1;
        grant[w_sel] = 1'b1;
        index        = w_sel;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sqrt_sched.sv
// ============================================================================
// sqrt_sched : shares one iterative sqrt engine among NREQ requesters.
// Optional watchdog enabled by macro SQRT_SCHED_TIMEOUT_EN.  Revision: 1.0
// ============================================================================
`default_nettype none

module sqrt_sched
  import sqrt_sched_pkg::*;
#(
  parameter int NREQ    = c_nreq_def,
  parameter int WIDTH   = c_width_def,
  parameter int TIMEOUT = c_timeout_def
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NREQ-1:0]               req_valid,
  input  logic [NREQ-1:0][WIDTH-1:0]    req_rad,
  output logic [NREQ-1:0]               req_ready,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [id_width(NREQ)-1:0]     rsp_id,
  output logic [WIDTH-1:0]              rsp_root,
  output logic [WIDTH-1:0]              rsp_rem,
  output logic                          rsp_err,
  output logic                          eng_start,
  output logic [WIDTH-1:0]              eng_rad,
  input  logic                          eng_busy,
  input  logic                          eng_valid,
  input  logic [WIDTH-1:0]              eng_root,
  input  logic [WIDTH-1:0]              eng_rem
);

  localparam int c_idw = id_width(NREQ);

  state_e           r_state, w_next;
  logic [c_idw-1:0] r_ptr, r_id, w_idx, w_ptr_nxt;
  logic [WIDTH-1:0] r_rad, r_root, r_rem;
  logic [NREQ-1:0]  w_grant;
  logic             w_arb_en, w_go, w_done, w_to;

  // Grants are withheld during reset and while the engine is still busy
  assign w_arb_en = (r_state == IDLE) && !eng_busy && rst_n;
  assign w_go     = |w_grant;
  assign w_done   = (r_state == WAIT) && eng_valid && !eng_busy;
  assign w_ptr_nxt = (w_idx == c_idw'(NREQ - 1)) ? '0 : w_idx + 1'b1;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (c_idw)
  ) u_arb (
    .req     (req_valid),
    .pointer (r_ptr),
    .enable  (w_arb_en),
    .grant   (w_grant),
    .index   (w_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_go) w_next = START;
      START:   w_next = WAIT;
      WAIT:    if (w_done || w_to) w_next = HOLD;
      HOLD:    if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr  <= '0;
      r_id   <= '0;
      r_rad  <= '0;
      r_root <= '0;
      r_rem  <= '0;
    end else begin
      if (r_state == IDLE && w_go) begin
        r_rad <= req_rad[w_idx];
        r_id  <= w_idx;
        r_ptr <= w_ptr_nxt;
      end
      if (w_done) begin
        r_root <= eng_root;
        r_rem  <= eng_rem;
      end else if (w_to) begin
        r_root <= '0;
        r_rem  <= '0;
      end
    end
  end

`ifdef SQRT_SCHED_TIMEOUT_EN
  localparam int c_cnt_w = $clog2(TIMEOUT + 1);

  logic [c_cnt_w-1:0] r_cnt;
  logic               r_err;

  // Expires on the TIMEOUT-th consecutive WAIT cycle without a result
  assign w_to = (r_state == WAIT) && !w_done && (r_cnt == c_cnt_w'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == START)     r_cnt <= '0;
      else if (r_state == WAIT) r_cnt <= r_cnt + 1'b1;
      if (w_done)               r_err <= 1'b0;
      else if (w_to)            r_err <= 1'b1;
    end
  end

  assign rsp_err = r_err;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT > 0);
  assign w_to    = 1'b0;
  assign rsp_err = 1'b0;
`endif

  assign req_ready = w_grant;
  assign eng_start = (r_state == START);
  assign eng_rad   = r_rad;
  assign rsp_valid = (r_state == HOLD);
  assign rsp_id    = r_id;
  assign rsp_root  = r_root;
  assign rsp_rem   = r_rem;

endmodule

`default_nettype wire
